// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path and its FIFO.
//
// Contents:
//   uart_state_t      - transmitter state encoding
//                       (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP)
//   UART_DATA_W       - data bits per frame (8)
//   UART_BAUD_W       - width of the baud counter (covers DIV up to 65535)
//   UART_CLK_HZ       - system clock frequency (4.028 MHz dot clock)
//   UART_BAUD_HZ      - default line rate
//   UART_DEFAULT_DIV  - clocks per bit for the default rate at UART_CLK_HZ
//
// Optional feature macro used by files importing this package:
//   UART_TX_PARITY_EN  - adds a parity bit between data and stop bits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int UART_DATA_W  = 8;
  localparam int UART_BAUD_W  = 16;
  localparam int UART_CLK_HZ  = 4028000;
  localparam int UART_BAUD_HZ = 115200;

  // Rounded to nearest: 4028000 / 115200 = 34.97 -> 35.
  localparam int UART_DEFAULT_DIV = (UART_CLK_HZ + UART_BAUD_HZ / 2) / UART_BAUD_HZ;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous single-clock byte FIFO.
//
// Parameters:
//   DEPTH - number of entries, power of two (2..16)
//   W     - entry width in bits
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset (flushes the FIFO)
//   push, wdata - write request and data; ignored while full
//   pop         - read request; ignored while empty
//   rdata       - head entry (valid when !empty), combinational from storage
//   count       - number of entries held (0..DEPTH)
//   full, empty - count == DEPTH, count == 0
//
// A push and a pop in the same cycle both take effect and leave count
// unchanged. Pointers are $clog2(DEPTH) bits wide, so they wrap modulo DEPTH
// without extra logic.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 serial transmitter fed by a small byte FIFO.
//
// Parameters:
//   DIV   - clocks per bit (2..65535), default 35 (115200 baud at 4.028 MHz)
//   DEPTH - FIFO depth in bytes, power of two (2..16)
//
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset; aborts any frame, flushes FIFO
//   tx_data    - byte to queue
//   tx_valid   - tx_data valid this cycle
//   tx_ready   - FIFO not full
//   parity_odd - (UART_TX_PARITY_EN only) 0 = even, 1 = odd parity,
//                sampled when a byte is popped
//   TX         - serial line, idle high, driven straight from a flop
//   busy       - frame in progress or bytes queued
//   fifo_count - bytes currently queued
//
// Handshake: a byte is taken on every rising edge where tx_valid && tx_ready;
// tx_valid while tx_ready is low is ignored and the byte is lost. tx_valid
// need not stay asserted, and tx_ready does not depend on tx_valid.
//
// Optional feature macro: UART_TX_PARITY_EN adds the parity_odd port and a
// PARITY bit between the data bits and the stop bit (frame = 11*DIV clocks
// instead of 10*DIV).
//
// The FSM state register state_q is the point to observe transmitter state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIV   = UART_DEFAULT_DIV,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                   parity_odd,
`endif
  output logic                   TX,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam logic [UART_BAUD_W-1:0] BAUD_LAST = UART_BAUD_W'(DIV - 1);

  uart_state_t            state_q, state_d;
  logic [UART_BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic                   fifo_pop;
  logic [UART_DATA_W-1:0] fifo_rdata;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   bit_end;

  uart_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready = !fifo_full;
  assign TX       = tx_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          par_d    = (^fifo_rdata) ^ parity_odd;
`endif
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Queued byte starts its start bit immediately: no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d    = (^fifo_rdata) ^ parity_odd;
`endif
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo (DIV=4, DEPTH=4).
//
// The reference model works at the line level: a queue of accepted bytes, the
// byte currently on the wire and the number of clocks since its start bit
// began. Expected TX is derived from that offset by integer division by DIV.
// Every cycle TX, tx_ready, busy and fifo_count are compared with the model.
// Honours UART_TX_PARITY_EN (drives parity_odd randomly, expects 11-bit frames).
module tb_uart_tx_fifo;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       parity_odd = 1'b0;
  logic       tx_ready;
  logic       tx_line;
  logic       busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DIV   (DIV),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .TX         (tx_line),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [7:0] exp_q[$];       // bytes accepted but not yet on the wire
  logic [7:0] m_cur;          // byte currently being sent
  logic       m_par;          // its parity bit
  logic       m_active;       // a frame is on the wire
  int         m_off;          // clocks since its start bit began
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_frames = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    else
      n_pass++;
  endtask

  // Advance the model across one rising edge using the inputs seen at it.
  task automatic model_edge();
    bit can_push;
    if (reset) begin
      exp_q.delete();
      m_active = 1'b0;
      m_off    = 0;
      return;
    end
    can_push = (exp_q.size() < DEPTH);
    if (m_active) begin
      m_off++;
      if (m_off == FRAME_BITS * DIV) m_active = 1'b0;
    end
    if (!m_active && exp_q.size() != 0) begin
      m_cur    = exp_q.pop_front();
      m_par    = (^m_cur) ^ parity_odd;
      m_active = 1'b1;
      m_off    = 0;
      n_frames++;
    end
    if (tx_valid && can_push) exp_q.push_back(tx_data);
  endtask

  function automatic logic model_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_off / DIV;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return m_par;
`endif
    return 1'b1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    reset      = rst;
    tx_valid   = v;
    tx_data    = d;
    parity_odd = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge();
    #1;
    check_eq("tx",         32'(tx_line),    32'(model_tx()));
    check_eq("tx_ready",   32'(tx_ready),   32'(exp_q.size() != DEPTH));
    check_eq("busy",       32'(busy),       32'(m_active || exp_q.size() != 0));
    check_eq("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_active = 1'b0;
    m_off    = 0;
    m_cur    = 8'h00;
    m_par    = 1'b0;

    // Reset held with tx_valid asserted: nothing may be queued.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'hC3);
    idle(3);

    // Single byte.
    step(1'b0, 1'b1, 8'h55);
    idle(10 * DIV + 6);
    check_eq("frames_after_single", 32'(n_frames), 32'd1);

    // Back-to-back frames.
    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h3C);
    idle(2 * FRAME_BITS * DIV + 6);

    // Overflow: six consecutive pushes, the sixth must be dropped.
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
    idle(5 * FRAME_BITS * DIV + 6);
    check_eq("frames_after_overflow", 32'(n_frames), 32'd8);

    // Reset during data bit 3 of 0xFF with two bytes queued.
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    idle(15);
    step(1'b1, 1'b0, 8'h00);
    idle(3 * FRAME_BITS * DIV);
    check_eq("frames_after_abort", 32'(n_frames), 32'd9);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 99) < 30),
           8'($urandom_range(0, 255)));
    idle((DEPTH + 1) * FRAME_BITS * DIV + 10);
    check_eq("drained_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial 8N1 transmitter with a small byte FIFO; drives the TX line of the 6502 system's serial port.
- Sits between the CPU-side ACIA register interface and the TX pin.
- Also used as a host-side stimulus source into the core's RX pin.
- Fixed integer baud divider; one clock domain; no oversampling needed on transmit.

Parameters:
- DIV, 35, clocks per bit (4.028 MHz / 115200 ≈ 35); legal range 2..65535.
- DEPTH, 4, FIFO depth in bytes; power of two, 2..16.

Ports:
- clk  input  1  system clock (4.028 MHz dot clock).
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data valid this cycle.
- tx_ready  output  1  FIFO can accept a byte (not full).
- TX  output  1  serial line; idle high.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  $clog2(DEPTH)+1  bytes currently queued.

Behaviour:
- Reset values: TX=1, tx_ready=1, busy=0, fifo_count=0. State=IDLE, baud counter=0, bit index=0, FIFO pointers=0.
- Reset mid-frame aborts the frame immediately: TX=1 on the next edge, FIFO is flushed.
- Push:
  - A byte is accepted on an edge where tx_valid && tx_ready.
  - tx_ready = (fifo_count != DEPTH), registered-consistent with the count.
  - tx_valid while full is ignored; the byte is dropped and state is unchanged.
- Pop: only in IDLE, or at the end of the STOP bit, when fifo_count != 0.
- Simultaneous push and pop: count unchanged; both take effect.
- Pointers wrap modulo DEPTH. Data is emitted in FIFO order.
- States:
  - IDLE: TX=1. If the FIFO is non-empty, pop into the shift register, TX=0, go to START with baud counter cleared.
  - START: hold TX=0 for DIV clocks, then go to DATA with bit index 0, TX=shift[0].
  - DATA: hold each bit DIV clocks, LSB first. After bit 7 completes, go to STOP with TX=1.
  - STOP: hold TX=1 for DIV clocks. Then:
    - FIFO non-empty: pop and go directly to START (no idle gap; back-to-back frames).
    - Otherwise: go to IDLE.
- Latency: if a byte is pushed into an empty FIFO at edge k while in IDLE, TX falls at edge k+1.
- Frame length: exactly 10*DIV clocks (11*DIV with parity).
- Baud counter counts 0..DIV-1 and wraps on each bit boundary.
- busy = (state != IDLE) || (fifo_count != 0).
- TX is driven directly from a flop (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, held DIV clocks.
  - Parity bit = XOR of the 8 data bits ^ input parity_odd.
  - Adds port parity_odd  input  1  (0=even, 1=odd), sampled at pop time.
- Undefined: no parity state and no parity_odd port; 8N1 only.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP;
  - UART_DATA_W=8;
  - helper constant for the default DIV at the 4.028 MHz clock.
- One natural sub-module: uart_fifo.
  - Synchronous FIFO with push/pop/count/full/empty and a DEPTH parameter.
  - Also reusable on the receive side.

Test Plan:
- Reset: with DIV=4, hold reset 4 clocks while tx_valid=1 -> TX=1, tx_ready=1, busy=0, fifo_count=0 throughout; nothing queued.
- Single byte: push 0x55 at edge k (DIV=4) -> TX=0 from edge k+1 for 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then stop=1; busy drops at edge k+41.
- Back-to-back: push 0xA5, 0x3C on consecutive cycles -> two frames with no gap; second start bit begins exactly 40 clocks after the first; sampled bytes equal 0xA5 then 0x3C.
- Full/overflow (DEPTH=4): push 6 bytes 0x01..0x06 in consecutive cycles.
  - First byte popped at the edge after its push, so 0x01..0x05 are accepted.
  - tx_ready=0 when fifo_count=4; 0x06 is dropped.
  - Line carries 0x01..0x05 only.
- Reset mid-frame: assert reset during bit 3 of 0xFF with 2 bytes queued -> TX=1 next edge, fifo_count=0; no further frames after release.
- Parity (UART_TX_PARITY_EN, parity_odd=0): send 0x07 -> parity bit=1, frame=11*DIV clocks; with parity_odd=1 -> parity bit=0.
